knn_topk_core: RTL and testbench
================================

Name: knn_topk_core

Overview:
Parametrised successor to the two-point squared-distance KNN core. Accepts a DIM-dimensional test point, then a stream of labelled DIM-dimensional neighbours. For each neighbour it computes the squared Euclidean distance and keeps a sorted list of the K nearest. Sits behind the KNN peripheral register interface; firmware loads points, waits for done, then reads ranks.

Parameters:
DATA_W, 16, unsigned coordinate width
DIM, 2, coordinates per point (>=1)
K, 4, neighbours retained (>=1)
LABEL_W, 8, neighbour class label width
DIST_W, 2*DATA_W+$clog2(DIM+1), distance width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
start  in  1  pulse: clear list and counters, enter LOAD_TEST
test_valid  in  1  test coordinate beat valid
test_data  in  DATA_W  test coordinate, dim 0 first
nb_valid  in  1  neighbour coordinate beat valid
nb_ready  out  1  core accepts neighbour beat
nb_data  in  DATA_W  neighbour coordinate, dim 0 first
nb_label  in  LABEL_W  label, sampled on last coordinate beat of each neighbour
nb_last  in  1  marks last coordinate beat of last neighbour
done  out  1  list final
nb_count  out  16  neighbours inserted, saturating at 65535
rd_idx  in  $clog2(K)  rank to read, 0 = nearest
rd_dist  out  DIST_W  distance at rank rd_idx
rd_label  out  LABEL_W  label at rank rd_idx
rd_valid  out  1  rank rd_idx holds a real entry
vote_label  out  LABEL_W  majority label (KNN_VOTE_EN only)

Behaviour:
- Reset (rst low, async): state IDLE; nb_ready=0, done=0, nb_count=0, all entries invalid with dist=all-ones, label=0; rd_* and vote_label read 0.
- FSM: IDLE -> (start) LOAD_TEST -> (DIM test beats) STREAM -> (DIM-th accepted nb beat) INSERT -> STREAM, or DONE if that beat had nb_last. DONE holds until start.
- start is accepted in any state, restarts from LOAD_TEST, and discards any partial accumulation. It takes precedence over same-cycle beats, which are dropped.
- LOAD_TEST: a coord counter (0..DIM-1) stores test_data per test_valid. nb_ready=0.
- STREAM: nb_ready=1. Each accepted beat adds (|test[c]-nb_data|)^2 to the accumulator. The abs diff is DATA_W bits and the square is 2*DATA_W bits. The sum never overflows DIST_W.
- Accumulator clears when the neighbour completes.
- INSERT: exactly one cycle, nb_ready=0. The new entry is compared in parallel against all K entries. It is inserted at the first rank whose dist is strictly greater, and lower ranks shift down with rank K-1 dropped. Ties go after existing equal entries (stable). If no rank is greater, the entry is discarded.
- nb_count increments in INSERT whether or not the entry is retained.
- Throughput: one neighbour per DIM+1 cycles.
- nb_last on a non-final coordinate beat is ignored. Only the beat that completes a neighbour can end the stream.
- done asserts the cycle after the final INSERT and clears on start.
- rd_dist/rd_label/rd_valid are combinational from rd_idx and valid in any state. rd_idx>=K returns zeros.

Optional Feature:
KNN_VOTE_EN defined:
- vote_label is the label with the highest occurrence count among valid entries.
- A count tie resolves to the tied label whose best rank is nearest.
- With no valid entries, vote_label=0.
- Registered; updates the cycle after each INSERT.
KNN_VOTE_EN undefined: vote_label is tied to 0 and no counting logic is built.

Decomposition:
- Shared header knn_defs.vh holds:
  - DIST_W derivation macro
  - FSM state encodings (IDLE=0, LOAD_TEST=1, STREAM=2, INSERT=3, DONE=4)
  - the all-ones "empty" distance constant
- Sub-module knn_sqdist: per-beat abs-diff, square and accumulate, with a clear input. The top holds the FSM, sorted list and vote logic.

Test Plan:
- DIM=2, K=4. Test (4,2); neighbours (3,1)L1, (4,2)L2, (0,0)L3 -> rank0 dist0 L2, rank1 dist2 L1, rank2 dist20 L3, rank3 rd_valid=0; nb_count=3.
- K=2, six neighbours with distances 9,1,4,1,16,0 -> rank0 dist0, rank1 dist1 (first-arrived of the tie); nb_count=6.
- nb_valid held high throughout -> nb_ready low exactly one cycle per neighbour; done exactly 1 cycle after the last INSERT.
- start pulsed mid-neighbour (after 1 of 2 coords), then reload and stream (1,1) vs test (0,0) -> rank0 dist2; no residue from the aborted beat.
- rst low mid-STREAM -> all outputs 0 immediately (async), nb_ready=0; no insert after rst rises.
- KNN_VOTE_EN, K=3, labels ranks0..2 = 5,7,7 -> vote 7. Labels 5,7,9 -> vote 5. Undefined -> vote_label=0.

Source files
------------

// File: rtl/knn_topk_core_pkg.sv
// Shared definitions for the KNN top-K core: FSM state encoding, the
// neighbour counter width and the distance-width derivation.
package knn_topk_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_TEST = 3'd1,
        ST_STREAM    = 3'd2,
        ST_INSERT    = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam int COUNT_W = 16;

    // A square of a DATA_W-bit difference needs 2*DATA_W bits; summing DIM of
    // them needs clog2(DIM+1) guard bits so the sum can never wrap.
    function automatic int dist_width(input int data_w, input int dim);
        return 2 * data_w + $clog2(dim + 1);
    endfunction

endpackage

// File: rtl/knn_sqdist.sv
// Per-beat squared-distance accumulator: |a-b|^2 is added to acc on every
// enabled beat; clear empties the accumulator and wins over en.
module knn_sqdist
    import knn_topk_core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIST_W = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DIST_W-1:0] acc
);

    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] sq;

    // Absolute difference and its square for the current beat.
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first); a path that leaves one unassigned infers a latch.
    always_comb begin
        diff = '0;
        sq   = '0;
        diff = (a >= b) ? (a - b) : (b - a);
        sq   = {{DATA_W{1'b0}}, diff} * {{DATA_W{1'b0}}, diff};
    end

    // Running sum of squares for the neighbour in flight.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(DIST_W - 2*DATA_W){1'b0}}, sq};
        end
    end

endmodule

// File: rtl/knn_topk_core.sv
// KNN top-K core: loads a DIM-coordinate test point, streams labelled
// neighbours, keeps the K nearest in a stable sorted list.
// Optional majority vote output is built only when KNN_VOTE_EN is defined.
module knn_topk_core
    import knn_topk_core_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  DIM     = 2,
    parameter int  K       = 4,
    parameter int  LABEL_W = 8,
    localparam int DIST_W  = dist_width(DATA_W, DIM),
    localparam int IDX_W   = (K > 1) ? $clog2(K) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               test_valid,
    input  logic [DATA_W-1:0]  test_data,
    input  logic               nb_valid,
    output logic               nb_ready,
    input  logic [DATA_W-1:0]  nb_data,
    input  logic [LABEL_W-1:0] nb_label,
    input  logic               nb_last,
    output logic               done,
    output logic [COUNT_W-1:0] nb_count,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DIST_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [LABEL_W-1:0] vote_label
);

    localparam int CNT_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int NSLOT = 1 << IDX_W;
    localparam logic [DIST_W-1:0] EMPTY_DIST = '1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     coord_q;
    logic [DATA_W-1:0]    test_pt [DIM];
    logic [LABEL_W-1:0]   pend_label;
    logic                 pend_last;
    logic                 test_beat, nb_beat, last_coord;
    logic [DIST_W-1:0]    acc;
    logic [DIST_W-1:0]    dist_q  [K];
    logic [DIST_W-1:0]    dist_d  [K];
    logic [LABEL_W-1:0]   label_q [K];
    logic [LABEL_W-1:0]   label_d [K];
    logic [K-1:0]         valid_q, valid_d, gt;
    logic [COUNT_W-1:0]   count_q;

    assign last_coord = (coord_q == CNT_W'(DIM - 1));
    assign nb_ready   = (state_q == ST_STREAM) && !start;
    assign test_beat  = (state_q == ST_LOAD_TEST) && test_valid && !start;
    assign nb_beat    = nb_ready && nb_valid;
    assign done       = (state_q == ST_DONE);
    assign nb_count   = count_q;

    knn_sqdist #(.DATA_W(DATA_W), .DIST_W(DIST_W)) u_sqdist (
        .clk   (clk),
        .rst   (rst),
        .clear (start || (state_q == ST_INSERT)),
        .en    (nb_beat),
        .a     (test_pt[coord_q]),
        .b     (nb_data),
        .acc   (acc)
    );

    // Next-state logic; start restarts from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD_TEST;
        end else begin
            case (state_q)
                ST_LOAD_TEST: if (test_beat && last_coord) state_d = ST_STREAM;
                ST_STREAM:    if (nb_beat && last_coord)   state_d = ST_INSERT;
                ST_INSERT:    state_d = pend_last ? ST_DONE : ST_STREAM;
                default:      state_d = state_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Coordinate counter and the label/last flag captured on a neighbour's final beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coord_q    <= '0;
            pend_label <= '0;
            pend_last  <= 1'b0;
        end else begin
            if (start)
                coord_q <= '0;
            else if (test_beat || nb_beat)
                coord_q <= last_coord ? '0 : coord_q + 1'b1;
            if (nb_beat && last_coord) begin
                pend_label <= nb_label;
                pend_last  <= nb_last;
            end
        end
    end

    // Test point storage.
    // NOTE: no reset here; every coordinate is rewritten in LOAD_TEST before
    // STREAM can read it, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (test_beat) test_pt[coord_q] <= test_data;
    end

    // Stable sorted insert: the new entry lands at the first rank whose
    // distance is strictly greater; everything from there shifts down one.
    always_comb begin
        dist_d  = dist_q;
        label_d = label_q;
        valid_d = valid_q;
        gt      = '0;
        for (int i = 0; i < K; i++)
            gt[i] = !valid_q[i] || (dist_q[i] > acc);
        if (start) begin
            for (int i = 0; i < K; i++) begin
                dist_d[i]  = EMPTY_DIST;
                label_d[i] = '0;
                valid_d[i] = 1'b0;
            end
        end else if (state_q == ST_INSERT) begin
            if (gt[0]) begin
                dist_d[0]  = acc;
                label_d[0] = pend_label;
                valid_d[0] = 1'b1;
            end
            for (int i = 1; i < K; i++) begin
                if (gt[i] && gt[i-1]) begin
                    dist_d[i]  = dist_q[i-1];
                    label_d[i] = label_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end else if (gt[i]) begin
                    dist_d[i]  = acc;
                    label_d[i] = pend_label;
                    valid_d[i] = 1'b1;
                end
            end
        end
    end

    // Sorted list registers; empty entries hold the all-ones distance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                dist_q[i]  <= EMPTY_DIST;
                label_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            dist_q  <= dist_d;
            label_q <= label_d;
            valid_q <= valid_d;
        end
    end

    // Saturating count of completed neighbours, retained or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else if (start)
            count_q <= '0;
        else if ((state_q == ST_INSERT) && (count_q != '1))
            count_q <= count_q + 1'b1;
    end

    // Rank read port, padded to a power of two so out-of-range ranks read zero.
    logic [DIST_W-1:0]  slot_dist  [NSLOT];
    logic [LABEL_W-1:0] slot_label [NSLOT];
    logic [NSLOT-1:0]   slot_valid;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < K) begin : g_live
            assign slot_valid[g] = valid_q[g];
            assign slot_dist[g]  = valid_q[g] ? dist_q[g]  : '0;
            assign slot_label[g] = valid_q[g] ? label_q[g] : '0;
        end else begin : g_pad
            assign slot_valid[g] = 1'b0;
            assign slot_dist[g]  = '0;
            assign slot_label[g] = '0;
        end
    end

    assign rd_valid = slot_valid[rd_idx];
    assign rd_dist  = slot_dist[rd_idx];
    assign rd_label = slot_label[rd_idx];

`ifdef KNN_VOTE_EN
    localparam int CW = $clog2(K + 1);

    logic [LABEL_W-1:0] vote_d, vote_q;
    logic [CW-1:0]      cnt_tmp, best_cnt;

    // Majority label over the post-insert list; scanning ranks nearest-first
    // with a strict compare resolves count ties to the nearest-ranked label.
    always_comb begin
        vote_d   = '0;
        best_cnt = '0;
        cnt_tmp  = '0;
        for (int i = 0; i < K; i++) begin
            cnt_tmp = '0;
            for (int j = 0; j < K; j++)
                if (valid_d[i] && valid_d[j] && (label_d[j] == label_d[i]))
                    cnt_tmp = cnt_tmp + 1'b1;
            if (cnt_tmp > best_cnt) begin
                best_cnt = cnt_tmp;
                vote_d   = label_d[i];
            end
        end
    end

    // Vote register, refreshed by each INSERT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       vote_q <= '0;
        else if (start)                 vote_q <= '0;
        else if (state_q == ST_INSERT)  vote_q <= vote_d;
    end

    assign vote_label = vote_q;
`else
    assign vote_label = '0;
`endif

endmodule

// File: tb/tb_knn_topk_core.sv
// Self-checking bench for knn_topk_core (DIM=2, K=4); a queue-based
// reference model supplies every expected rank, count and vote.
`timescale 1ns/1ps
module tb_knn_topk_core;

    localparam int DATA_W  = 16;
    localparam int DIM     = 2;
    localparam int K       = 4;
    localparam int LABEL_W = 8;
    localparam int DIST_W  = 2*DATA_W + $clog2(DIM+1);

    logic               clk = 1'b0;
    logic               rst;
    logic               start, test_valid, nb_valid, nb_last;
    logic [DATA_W-1:0]  test_data, nb_data;
    logic [LABEL_W-1:0] nb_label;
    logic               nb_ready, done, rd_valid;
    logic [15:0]        nb_count;
    logic [1:0]         rd_idx;
    logic [DIST_W-1:0]  rd_dist;
    logic [LABEL_W-1:0] rd_label, vote_label;

    knn_topk_core #(.DATA_W(DATA_W), .DIM(DIM), .K(K), .LABEL_W(LABEL_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .test_valid(test_valid), .test_data(test_data),
        .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_data(nb_data),
        .nb_label(nb_label), .nb_last(nb_last),
        .done(done), .nb_count(nb_count),
        .rd_idx(rd_idx), .rd_dist(rd_dist), .rd_label(rd_label),
        .rd_valid(rd_valid), .vote_label(vote_label)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: sorted neighbour list as parallel queues.
    longint mdl_dist [$];
    int     mdl_label[$];
    int     mdl_count;
    int     mt [DIM];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mdl_dist.delete();
        mdl_label.delete();
        mdl_count = 0;
    endtask

    task automatic model_insert(input longint d, input int l);
        int pos = mdl_dist.size();
        for (int i = 0; i < mdl_dist.size(); i++)
            if (mdl_dist[i] > d) begin pos = i; break; end
        if (pos < K) begin
            mdl_dist.insert(pos, d);
            mdl_label.insert(pos, l);
            if (mdl_dist.size() > K) begin
                void'(mdl_dist.pop_back());
                void'(mdl_label.pop_back());
            end
        end
        if (mdl_count < 65535) mdl_count++;
    endtask

    function automatic int model_vote();
        int cnt[int];
        int best = 0;
        int best_cnt = 0;
        foreach (mdl_label[i]) begin
            if (cnt.exists(mdl_label[i])) cnt[mdl_label[i]]++;
            else cnt[mdl_label[i]] = 1;
        end
        foreach (mdl_label[i])
            if (cnt[mdl_label[i]] > best_cnt) begin
                best_cnt = cnt[mdl_label[i]];
                best = mdl_label[i];
            end
`ifdef KNN_VOTE_EN
        return best;
`else
        return 0;
`endif
    endfunction

    function automatic longint sqd(input int a, input int b);
        longint d = longint'(a) - longint'(b);
        return d * d;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic load_test(input int a, input int b);
        mt[0] = a; mt[1] = b;
        test_valid = 1'b1;
        test_data = 16'(a);
        @(negedge clk);
        test_data = 16'(b);
        @(negedge clk);
        test_valid = 1'b0;
    endtask

    task automatic send_beat(input int d, input int l, input bit last);
        int n = 0;
        nb_valid = 1'b1;
        nb_data  = 16'(d);
        nb_label = 8'(l);
        nb_last  = last;
        while (!nb_ready && n < 20) begin @(negedge clk); n++; end
        check("ready_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        nb_valid = 1'b0;
        nb_last  = 1'b0;
    endtask

    task automatic send_nb(input int x0, input int x1, input int l, input bit last);
        send_beat(x0, l, 1'b0);
        send_beat(x1, l, last);
        model_insert(sqd(mt[0], x0) + sqd(mt[1], x1), l);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_rank(input string tag, input int r, input longint d, input int l, input bit v);
        rd_idx = 2'(r);
        #1;
        check({tag, "_valid"}, 64'(rd_valid), 64'(v));
        check({tag, "_dist"},  64'(rd_dist),  64'(d));
        check({tag, "_label"}, 64'(rd_label), 64'(l));
    endtask

    task automatic check_list(input string tag);
        for (int r = 0; r < K; r++) begin
            if (r < mdl_dist.size())
                check_rank($sformatf("%s_r%0d", tag, r), r, mdl_dist[r], mdl_label[r], 1'b1);
            else
                check_rank($sformatf("%s_r%0d", tag, r), r, 0, 0, 1'b0);
        end
        check({tag, "_count"}, 64'(nb_count),   64'(mdl_count));
        check({tag, "_vote"},  64'(vote_label), 64'(model_vote()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats[6];
        int lbls[3];
        int idx, lows, cyc, rng, n;
        rst = 1'b0; start = 1'b0; test_valid = 1'b0; test_data = '0;
        nb_valid = 1'b0; nb_data = '0; nb_label = '0; nb_last = 1'b0; rd_idx = '0;
        model_clear();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(nb_ready), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_count", 64'(nb_count), 64'd0);
        check("rst_vote",  64'(vote_label), 64'd0);
        for (int r = 0; r < K; r++) check_rank($sformatf("rst_r%0d", r), r, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Directed: test (4,2), three neighbours.
        do_start();
        check("load_ready", 64'(nb_ready), 64'd0);
        load_test(4, 2);
        send_nb(3, 1, 1, 1'b0);
        send_nb(4, 2, 2, 1'b0);
        send_nb(0, 0, 3, 1'b1);
        wait_done();
        check_rank("t1_r0", 0, 0, 2, 1'b1);
        check_rank("t1_r1", 1, 2, 1, 1'b1);
        check_rank("t1_r2", 2, 20, 3, 1'b1);
        check_rank("t1_r3", 3, 0, 0, 1'b0);
        check("t1_count", 64'(nb_count), 64'd3);
        check_list("t1");

        // Directed: distances 9,1,4,1,16,0 with a tie at 1.
        do_start();
        load_test(0, 0);
        send_nb(3, 0, 1, 1'b0);
        send_nb(1, 0, 2, 1'b0);
        send_nb(0, 2, 3, 1'b0);
        send_nb(0, 1, 4, 1'b0);
        send_nb(4, 0, 5, 1'b0);
        send_nb(0, 0, 6, 1'b1);
        wait_done();
        check_rank("t2_r0", 0, 0, 6, 1'b1);
        check_rank("t2_r1", 1, 1, 2, 1'b1);
        check("t2_count", 64'(nb_count), 64'd6);
        check_list("t2");

        // nb_valid held high: one ready-low cycle per neighbour boundary.
        do_start();
        load_test(5, 5);
        beats = '{1, 9, 5, 5, 7, 2};
        lbls  = '{3, 4, 5};
        idx = 0; lows = 0; cyc = 0;
        nb_valid = 1'b1;
        while (idx < 6 && cyc < 50) begin
            if (nb_ready) begin
                nb_data  = 16'(beats[idx]);
                nb_label = 8'(lbls[idx/2]);
                nb_last  = (idx == 5);
                idx++;
            end else begin
                lows++;
            end
            cyc++;
            @(negedge clk);
        end
        check("held_lows", 64'(lows), 64'd2);
        check("held_insert_ready", 64'(nb_ready), 64'd0);
        check("held_insert_done",  64'(done), 64'd0);
        @(negedge clk);
        check("held_done", 64'(done), 64'd1);
        check("held_done_ready", 64'(nb_ready), 64'd0);
        nb_valid = 1'b0; nb_last = 1'b0;
        for (int j = 0; j < 3; j++)
            model_insert(sqd(5, beats[2*j]) + sqd(5, beats[2*j+1]), lbls[j]);
        check_list("held");

        // start mid-neighbour, with a same-cycle beat that must be dropped.
        do_start();
        load_test(0, 0);
        send_beat(200, 0, 1'b0);
        start = 1'b1; nb_valid = 1'b1; nb_data = 16'd200;
        @(negedge clk);
        start = 1'b0; nb_valid = 1'b0;
        model_clear();
        check("abort_ready", 64'(nb_ready), 64'd0);
        load_test(0, 0);
        send_nb(1, 1, 9, 1'b1);
        wait_done();
        check_rank("abort_r0", 0, 2, 9, 1'b1);
        check_list("abort");

        // Asynchronous reset in the middle of STREAM.
        do_start();
        load_test(3, 3);
        send_nb(1, 1, 4, 1'b0);
        send_beat(7, 0, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_ready", 64'(nb_ready), 64'd0);
        check("arst_done",  64'(done), 64'd0);
        check("arst_count", 64'(nb_count), 64'd0);
        check("arst_vote",  64'(vote_label), 64'd0);
        check_rank("arst_r0", 0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        nb_valid = 1'b1; nb_data = 16'd1; nb_last = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_post_ready", 64'(nb_ready), 64'd0);
        check("arst_post_count", 64'(nb_count), 64'd0);
        check_rank("arst_post_r0", 0, 0, 0, 1'b0);
        nb_valid = 1'b0; nb_last = 1'b0;
        model_clear();

        // Vote cases: labels 5,7,7 then 5,7,9 by rank.
        do_start();
        load_test(0, 0);
        send_nb(1, 0, 5, 1'b0);
        send_nb(1, 1, 7, 1'b0);
        send_nb(2, 0, 7, 1'b1);
        wait_done();
        check_list("vote_a");
        do_start();
        load_test(0, 0);
        send_nb(1, 0, 5, 1'b0);
        send_nb(1, 1, 7, 1'b0);
        send_nb(2, 0, 9, 1'b1);
        wait_done();
        check_list("vote_b");

        // Randomized rounds, alternating narrow (tie-prone) and full range.
        for (int it = 0; it < 4; it++) begin
            rng = (it % 2 == 0) ? 7 : 65535;
            do_start();
            load_test(int'($urandom_range(0, rng)), int'($urandom_range(0, rng)));
            n = int'($urandom_range(3, 9));
            for (int j = 0; j < n; j++)
                send_nb(int'($urandom_range(0, rng)), int'($urandom_range(0, rng)),
                        int'($urandom_range(1, 3)), j == n - 1);
            wait_done();
            check_list($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
